// File: rtl/mem_write_checker_if.sv
// Data-memory write port of the MIPS core as observed by the write checker.
// The core side drives the master modport; the checker samples the slave modport.
interface mem_write_checker_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memwrite;
  logic [ADDR_W-1:0] dataadr;
  logic [DATA_W-1:0] writedata;

  modport master (
    output memwrite,
    output dataadr,
    output writedata
  );

  modport slave (
    input memwrite,
    input dataadr,
    input writedata
  );
endinterface

// File: rtl/mem_write_checker.sv
// Matches core data-memory writes against NUM_EXP expected (addr, data) pairs and reports pass/fail/timeout.
// Define MEMCHK_ORDERED_EN for strict in-order matching; otherwise entries may be hit in any order.
module mem_write_checker #(
  parameter int                          ADDR_W      = 32,
  parameter int                          DATA_W      = 32,
  parameter int                          NUM_EXP     = 1,
  parameter logic [NUM_EXP*ADDR_W-1:0]   EXP_ADDR    = 32'd84,
  parameter logic [NUM_EXP*DATA_W-1:0]   EXP_DATA    = 32'd7,
  parameter logic [ADDR_W-1:0]           IGN_ADDR    = 32'd80,
  parameter int                          TIMEOUT_CYC = 1000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  mem_write_checker_if.slave             bus,
  output logic                           pass,
  output logic                           fail,
  output logic                           done,
  output logic [1:0]                     fail_code,
  output logic [ADDR_W-1:0]              fail_addr,
  output logic [DATA_W-1:0]              fail_data,
  output logic [$clog2(NUM_EXP+1)-1:0]   hit_count,
  output logic [7:0]                     ign_count
);

  localparam int CW = $clog2(NUM_EXP + 1);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_UNEXP   = 2'd1;
  localparam logic [1:0] CODE_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_EXP-1:0]  hit_q, hit_d;
  logic [CW-1:0]       hit_count_q, hit_count_d;
  logic [7:0]          ign_count_q, ign_count_d;
  logic [TW-1:0]       cyc_q, cyc_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                done_q, done_d;
  logic [1:0]          fail_code_q, fail_code_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;

  logic [NUM_EXP-1:0]  entry_match;
  logic [NUM_EXP-1:0]  cand;
  logic [NUM_EXP-1:0]  sel;
  logic                any_match;
  logic                is_match;
  logic                is_ign;
  logic                is_bad;
  logic                completes;
  logic                timeout_now;
  logic                active;

  // Per-entry comparison and eligibility; eligibility is what differs between ordering modes.
  for (genvar gi = 0; gi < NUM_EXP; gi++) begin : g_entry
    assign entry_match[gi] = (bus.dataadr   == EXP_ADDR[gi*ADDR_W +: ADDR_W]) &&
                             (bus.writedata == EXP_DATA[gi*DATA_W +: DATA_W]);
`ifdef MEMCHK_ORDERED_EN
    assign cand[gi] = entry_match[gi] && (hit_count_q == CW'(gi));
`else
    assign cand[gi] = entry_match[gi] && !hit_q[gi];
`endif
  end

  // Isolate the lowest-index eligible entry so duplicate entries are consumed one at a time.
  assign sel       = cand & (~cand + NUM_EXP'(1));
  assign any_match = |cand;

  assign active      = (state_q == ST_RUN) && en;
  assign is_match    = active && bus.memwrite && any_match;
  assign is_ign      = active && bus.memwrite && !any_match && (bus.dataadr == IGN_ADDR);
  assign is_bad      = active && bus.memwrite && !any_match && (bus.dataadr != IGN_ADDR);
  assign completes   = is_match && (hit_count_q == CW'(NUM_EXP - 1));
  assign timeout_now = active && (TIMEOUT_CYC != 0) && (cyc_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    hit_count_d = hit_count_q;
    ign_count_d = ign_count_q;
    cyc_d       = cyc_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    done_d      = done_q;
    fail_code_d = fail_code_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;

    if (active && (TIMEOUT_CYC != 0)) begin
      cyc_d = cyc_q + TW'(1);
    end

    if (is_match) begin
      hit_d       = hit_q | sel;
      hit_count_d = hit_count_q + CW'(1);
    end

    if (is_ign && (ign_count_q != 8'hFF)) begin
      ign_count_d = ign_count_q + 8'd1;
    end

    // Same-edge precedence: completing match, then unexpected write, then timeout.
    if (completes) begin
      state_d = ST_PASS;
      pass_d  = 1'b1;
      done_d  = 1'b1;
    end else if (is_bad) begin
      state_d     = ST_FAIL;
      fail_d      = 1'b1;
      done_d      = 1'b1;
      fail_code_d = CODE_UNEXP;
      fail_addr_d = bus.dataadr;
      fail_data_d = bus.writedata;
    end else if (timeout_now) begin
      state_d     = ST_FAIL;
      fail_d      = 1'b1;
      done_d      = 1'b1;
      fail_code_d = CODE_TIMEOUT;
      fail_addr_d = '0;
      fail_data_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      hit_q       <= '0;
      hit_count_q <= '0;
      ign_count_q <= '0;
      cyc_q       <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_code_q <= CODE_NONE;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      hit_count_q <= hit_count_d;
      ign_count_q <= ign_count_d;
      cyc_q       <= cyc_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      done_q      <= done_d;
      fail_code_q <= fail_code_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign pass      = pass_q;
  assign fail      = fail_q;
  assign done      = done_q;
  assign fail_code = fail_code_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign hit_count = hit_count_q;
  assign ign_count = ign_count_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: four instances cover defaults, timeout, three-entry ordering and same-edge precedence.
// Expectations for the three-entry ordering case follow MEMCHK_ORDERED_EN when it is defined.
module tb_mem_write_checker;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [95:0] EXP3_ADDR = {32'h18, 32'h14, 32'h10};
  localparam logic [95:0] EXP3_DATA = {32'd3, 32'd2, 32'd1};

  // Instance a: defaults
  logic rst_a, en_a, pass_a, fail_a, done_a;
  logic [1:0] code_a;
  logic [31:0] faddr_a, fdata_a;
  logic [0:0] hit_a;
  logic [7:0] ign_a;
  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_write_checker dut_a (
    .clk(clk), .reset(rst_a), .en(en_a), .bus(bus_a),
    .pass(pass_a), .fail(fail_a), .done(done_a), .fail_code(code_a),
    .fail_addr(faddr_a), .fail_data(fdata_a), .hit_count(hit_a), .ign_count(ign_a)
  );

  // Instance b: short timeout
  logic rst_b, en_b, pass_b, fail_b, done_b;
  logic [1:0] code_b;
  logic [31:0] faddr_b, fdata_b;
  logic [0:0] hit_b;
  logic [7:0] ign_b;
  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();
  mem_write_checker #(.TIMEOUT_CYC(20)) dut_b (
    .clk(clk), .reset(rst_b), .en(en_b), .bus(bus_b),
    .pass(pass_b), .fail(fail_b), .done(done_b), .fail_code(code_b),
    .fail_addr(faddr_b), .fail_data(fdata_b), .hit_count(hit_b), .ign_count(ign_b)
  );

  // Instance c: three entries
  logic rst_c, en_c, pass_c, fail_c, done_c;
  logic [1:0] code_c;
  logic [31:0] faddr_c, fdata_c;
  logic [1:0] hit_c;
  logic [7:0] ign_c;
  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus_c ();
  mem_write_checker #(.NUM_EXP(3), .EXP_ADDR(EXP3_ADDR), .EXP_DATA(EXP3_DATA)) dut_c (
    .clk(clk), .reset(rst_c), .en(en_c), .bus(bus_c),
    .pass(pass_c), .fail(fail_c), .done(done_c), .fail_code(code_c),
    .fail_addr(faddr_c), .fail_data(fdata_c), .hit_count(hit_c), .ign_count(ign_c)
  );

  // Instance d: three entries, timeout after 3 cycles
  logic rst_d, en_d, pass_d, fail_d, done_d;
  logic [1:0] code_d;
  logic [31:0] faddr_d, fdata_d;
  logic [1:0] hit_d;
  logic [7:0] ign_d;
  mem_write_checker_if #(.ADDR_W(32), .DATA_W(32)) bus_d ();
  mem_write_checker #(.NUM_EXP(3), .EXP_ADDR(EXP3_ADDR), .EXP_DATA(EXP3_DATA), .TIMEOUT_CYC(3)) dut_d (
    .clk(clk), .reset(rst_d), .en(en_d), .bus(bus_d),
    .pass(pass_d), .fail(fail_d), .done(done_d), .fail_code(code_d),
    .fail_addr(faddr_d), .fail_data(fdata_d), .hit_count(hit_d), .ign_count(ign_d)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-16s ok   observed=%0h", tag, obs);
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each write occupies exactly one rising edge; returns at the following falling edge.
  task automatic wr_a(input logic [31:0] a, input logic [31:0] d);
    bus_a.memwrite = 1'b1; bus_a.dataadr = a; bus_a.writedata = d;
    @(negedge clk);
    bus_a.memwrite = 1'b0;
  endtask

  task automatic wr_c(input logic [31:0] a, input logic [31:0] d);
    $display("write c addr=%0h data=%0h", a, d);
    bus_c.memwrite = 1'b1; bus_c.dataadr = a; bus_c.writedata = d;
    @(negedge clk);
    bus_c.memwrite = 1'b0;
  endtask

  task automatic wr_d(input logic [31:0] a, input logic [31:0] d);
    $display("write d addr=%0h data=%0h", a, d);
    bus_d.memwrite = 1'b1; bus_d.dataadr = a; bus_d.writedata = d;
    @(negedge clk);
    bus_d.memwrite = 1'b0;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    bus_a.memwrite = 1'b0; bus_a.dataadr = '0; bus_a.writedata = '0;
    bus_b.memwrite = 1'b0; bus_b.dataadr = '0; bus_b.writedata = '0;
    bus_c.memwrite = 1'b0; bus_c.dataadr = '0; bus_c.writedata = '0;
    bus_d.memwrite = 1'b0; bus_d.dataadr = '0; bus_d.writedata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("a_rst_pass", pass_a, 0);
    check("a_rst_fail", fail_a, 0);
    check("a_rst_done", done_a, 0);
    check("a_rst_code", code_a, 0);
    check("a_rst_hit", hit_a, 0);
    check("a_rst_ign", ign_a, 0);
    check("a_rst_faddr", faddr_a, 0);
    check("a_rst_fdata", fdata_a, 0);

    // Ignored write then the expected write
    rst_a = 1'b1; en_a = 1'b1;
    $display("write a addr=80 data=55");
    wr_a(32'd80, 32'h55);
    check("a_ign1", ign_a, 1);
    check("a_nopass_yet", pass_a, 0);
    $display("write a addr=84 data=7");
    wr_a(32'd84, 32'd7);
    check("a_pass", pass_a, 1);
    check("a_pass_done", done_a, 1);
    check("a_pass_code", code_a, 0);
    check("a_pass_fail", fail_a, 0);
    check("a_pass_hit", hit_a, 1);
    $display("write a addr=84 data=6 (after pass)");
    wr_a(32'd84, 32'd6);
    check("a_pass_hold", pass_a, 1);
    check("a_pass_nofail", fail_a, 0);

    // Reset mid-life, then saturate the ignore counter
    rst_a = 1'b0; @(negedge clk); rst_a = 1'b1;
    check("a_rst2_hit", hit_a, 0);
    check("a_rst2_pass", pass_a, 0);
    check("a_rst2_ign", ign_a, 0);
    $display("write a addr=80 x260");
    for (int i = 0; i < 260; i++) wr_a(32'd80, 32'(i));
    check("a_ign_sat", ign_a, 8'd255);
    check("a_ign_nofail", fail_a, 0);

    // Wrong data
    $display("write a addr=84 data=6");
    wr_a(32'd84, 32'd6);
    check("a_bad_fail", fail_a, 1);
    check("a_bad_code", code_a, 1);
    check("a_bad_faddr", faddr_a, 84);
    check("a_bad_fdata", fdata_a, 6);
    check("a_bad_done", done_a, 1);
    $display("write a addr=84 data=7 (after fail)");
    wr_a(32'd84, 32'd7);
    check("a_late_nopass", pass_a, 0);
    check("a_late_fail", fail_a, 1);

    // Timeout at edge 20
    rst_b = 1'b1; en_b = 1'b1;
    $display("idle b 19 cycles");
    repeat (19) @(negedge clk);
    check("b_pre_to", fail_b, 0);
    @(negedge clk);
    check("b_to_fail", fail_b, 1);
    check("b_to_code", code_b, 2);
    check("b_to_faddr", faddr_b, 0);
    check("b_to_fdata", fdata_b, 0);

    // Timeout delayed by five disabled cycles
    rst_b = 1'b0; @(negedge clk); rst_b = 1'b1;
    check("b_rst_fail", fail_b, 0);
    $display("idle b 25 cycles, en low on 11..15");
    for (int k = 1; k <= 25; k++) begin
      en_b = !(k >= 11 && k <= 15);
      @(negedge clk);
      if (k == 20) check("b_en_at20", fail_b, 0);
      if (k == 24) check("b_en_at24", fail_b, 0);
    end
    check("b_en_at25", fail_b, 1);
    check("b_en_code", code_b, 2);

    // Out-of-order writes
    rst_c = 1'b1; en_c = 1'b1;
    wr_c(32'h14, 32'd2);
`ifdef MEMCHK_ORDERED_EN
    check("c_ord_fail", fail_c, 1);
    check("c_ord_code", code_c, 1);
    check("c_ord_faddr", faddr_c, 32'h14);
    check("c_ord_fdata", fdata_c, 2);
    wr_c(32'h10, 32'd1);
    wr_c(32'h18, 32'd3);
    check("c_ord_hold", faddr_c, 32'h14);
    check("c_ord_nopass", pass_c, 0);
`else
    check("c_any_hit1", hit_c, 1);
    check("c_any_nofail", fail_c, 0);
    wr_c(32'h10, 32'd1);
    check("c_any_hit2", hit_c, 2);
    check("c_any_nopass", pass_c, 0);
    wr_c(32'h18, 32'd3);
    check("c_any_pass", pass_c, 1);
    check("c_any_hit3", hit_c, 3);
    check("c_any_fail0", fail_c, 0);
`endif

    // Reset discards the hit mask
    rst_c = 1'b0; @(negedge clk); rst_c = 1'b1;
    wr_c(32'h10, 32'd1);
    check("c_pre_rst_hit", hit_c, 1);
    rst_c = 1'b0; @(negedge clk); rst_c = 1'b1;
    check("c_post_rst_hit", hit_c, 0);
    wr_c(32'h10, 32'd1);
    wr_c(32'h14, 32'd2);
    check("c_two_hit", hit_c, 2);
    check("c_two_nopass", pass_c, 0);
    wr_c(32'h18, 32'd3);
    check("c_three_pass", pass_c, 1);
    check("c_three_hit", hit_c, 3);

    // Repeat of an already-hit entry fails; ignore in between is tolerated
    rst_c = 1'b0; @(negedge clk); rst_c = 1'b1;
    wr_c(32'h10, 32'd1);
    wr_c(32'd80, 32'd9);
    check("c_mid_ign", ign_c, 1);
    check("c_mid_hit", hit_c, 1);
    wr_c(32'h10, 32'd1);
    check("c_rep_fail", fail_c, 1);
    check("c_rep_code", code_c, 1);
    check("c_rep_faddr", faddr_c, 32'h10);
    check("c_rep_fdata", fdata_c, 1);

    // Final match on the timeout edge
    rst_d = 1'b1; en_d = 1'b1;
    wr_d(32'h10, 32'd1);
    wr_d(32'h14, 32'd2);
    wr_d(32'h18, 32'd3);
    check("d_race_pass", pass_d, 1);
    check("d_race_fail", fail_d, 0);
    check("d_race_code", code_d, 0);
    check("d_race_hit", hit_d, 3);

    // Plain timeout with partial progress
    rst_d = 1'b0; @(negedge clk); rst_d = 1'b1;
    wr_d(32'h10, 32'd1);
    $display("idle d 2 cycles");
    @(negedge clk);
    check("d_to_pre", fail_d, 0);
    @(negedge clk);
    check("d_to_fail", fail_d, 1);
    check("d_to_code", code_d, 2);
    check("d_to_faddr", faddr_d, 0);
    check("d_to_hit", hit_d, 1);

    // Mismatch beats timeout on the same edge
    rst_d = 1'b0; @(negedge clk); rst_d = 1'b1;
    wr_d(32'h10, 32'd1);
    wr_d(32'h14, 32'd2);
    wr_d(32'h20, 32'd5);
    check("d_mm_code", code_d, 1);
    check("d_mm_faddr", faddr_d, 32'h20);
    check("d_mm_fdata", fdata_d, 5);
    check("d_mm_nopass", pass_d, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
